gsram_dp_init: RTL and testbench

Parametrised dual-port synchronous SRAM wrapper and successor to the fixed-size 1024x16 generic SRAM wrappers. It adds:
- per-byte write enables, built as one 8-bit generic_sram per byte lane;
- a cross-port write-first bypass;
- an optional output register stage with read-valid strobes;
- a hardware clear sequencer that fills the array with INIT_VAL after reset or on request.

It sits in accelerator private local memories, where kernels require a known-zero buffer before each invocation.

---
 rtl/gsram_dp_init.sv | 217 +++++++++++++++++++++
 tb/tb_gsram_dp_init.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gsram_dp_init.sv
// Dual-port SRAM wrapper built from 8-bit generic_sram lanes. Adds byte enables,
// a cross-port write-first bypass, an optional output register and a clear sequencer.

module generic_sram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          ce0,
  input  logic          we0,
  input  logic [AW-1:0] a0,
  input  logic [7:0]    d0,
  output logic [7:0]    q0,
  input  logic          ce1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [7:0]    d1,
  output logic [7:0]    q1
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (ce0 && we0)  mem[a0] <= d0;
    if (ce1 && we1)  mem[a1] <= d1;
    if (ce0 && !we0) q0 <= mem[a0];
    if (ce1 && !we1) q1 <= mem[a1];
  end
endmodule

module gsram_dp_init #(
  parameter int         ABITS    = 10,
  parameter int         DBITS    = 16,
  parameter bit         OUT_REG  = 1'b1,
  parameter logic [7:0] INIT_VAL = 8'h00
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               init_start,
  output logic               init_busy,
  output logic               init_done,
  input  logic [ABITS-1:0]   a0,
  input  logic [DBITS-1:0]   d0,
  input  logic [DBITS/8-1:0] be0,
  input  logic               ce0,
  input  logic               we0,
  output logic [DBITS-1:0]   q0,
  output logic               rv0,
  input  logic [ABITS-1:0]   a1,
  input  logic [DBITS-1:0]   d1,
  input  logic [DBITS/8-1:0] be1,
  input  logic               ce1,
  input  logic               we1,
  output logic [DBITS-1:0]   q1,
  output logic               rv1
);
  localparam int NB = DBITS / 8;
  localparam int CW = (ABITS > 1) ? ABITS - 1 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << (ABITS - 1)) - 1);

  typedef struct packed {
    logic             ce;
    logic             we;
    logic [ABITS-1:0] a;
    logic [DBITS-1:0] d;
    logic [NB-1:0]    be;
  } req_t;

  typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_READY} state_t;

  req_t [1:0] req;
  assign req[0] = {ce0, we0, a0, d0, be0};
  assign req[1] = {ce1, we1, a1, d1, be1};

  // Clear sequencer
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d, done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (init_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_RST;
    endcase
    busy_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_READY);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_RST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign init_busy = busy_q;
  assign init_done = done_q;

  logic clr, live;
  logic [1:0][ABITS-1:0] clr_a;
  assign clr      = (state_q == ST_CLEAR);
  assign live     = (state_q == ST_READY);
  assign clr_a[0] = ABITS'({cnt_q, 1'b0});
  assign clr_a[1] = ABITS'({cnt_q, 1'b1});

  // Array-side request steering
  logic                  same_a;
  logic [1:0]            u_rd, u_wr;
  logic [1:0][ABITS-1:0] s_a;
  logic [1:0][DBITS-1:0] s_d, s_q;
  logic [1:0][NB-1:0]    s_we, s_ce, fwd_d, fwd_q;

  always_comb begin
    same_a = (req[0].a == req[1].a);
    for (int p = 0; p < 2; p++) begin
      u_rd[p] = live & req[p].ce & ~req[p].we;
      u_wr[p] = live & req[p].ce & req[p].we;
      s_a[p]  = clr ? clr_a[p] : req[p].a;
      s_d[p]  = clr ? {NB{INIT_VAL}} : req[p].d;
    end
    for (int i = 0; i < NB; i++) begin
      // Port 0 owns any lane both ports write at the same address.
      s_we[0][i]  = clr | (u_wr[0] & req[0].be[i]);
      s_we[1][i]  = clr | (u_wr[1] & req[1].be[i] & ~(u_wr[0] & req[0].be[i] & same_a));
      fwd_d[0][i] = u_rd[0] & u_wr[1] & same_a & req[1].be[i];
      fwd_d[1][i] = u_rd[1] & u_wr[0] & same_a & req[0].be[i];
      for (int p = 0; p < 2; p++) s_ce[p][i] = s_we[p][i] | u_rd[p];
    end
  end

  // Bypass capture lines up with the array read so the lane mux sees both together.
  logic [1:0][DBITS-1:0] byp_q, rdat;
  logic [1:0]            rd_vld_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_q <= '0;
      fwd_q    <= '0;
      byp_q    <= '0;
    end else begin
      rd_vld_q <= u_rd;
      fwd_q    <= fwd_d;
      byp_q    <= {req[0].d, req[1].d};
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    generic_sram #(.AW(ABITS)) u_sram (
      .clk (clk),
      .ce0 (s_ce[0][i]),
      .we0 (s_we[0][i]),
      .a0  (s_a[0]),
      .d0  (s_d[0][8*i +: 8]),
      .q0  (s_q[0][8*i +: 8]),
      .ce1 (s_ce[1][i]),
      .we1 (s_we[1][i]),
      .a1  (s_a[1]),
      .d1  (s_d[1][8*i +: 8]),
      .q1  (s_q[1][8*i +: 8])
    );
    for (genvar p = 0; p < 2; p++) begin : g_port
      assign rdat[p][8*i +: 8] = fwd_q[p][i] ? byp_q[p][8*i +: 8] : s_q[p][8*i +: 8];
    end
  end

  // Output stage; out_q keeps the last returned word so q holds while rv is low.
  logic [1:0][DBITS-1:0] out_q, out_d;

  always_comb begin
    for (int p = 0; p < 2; p++) out_d[p] = rd_vld_q[p] ? rdat[p] : out_q[p];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) out_q <= '0;
    else       out_q <= out_d;
  end

  if (OUT_REG) begin : g_oreg
    logic [1:0] rv_q;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) rv_q <= '0;
      else       rv_q <= rd_vld_q;
    end
    assign q0  = out_q[0];
    assign q1  = out_q[1];
    assign rv0 = rv_q[0];
    assign rv1 = rv_q[1];
  end else begin : g_ocomb
    assign q0  = out_d[0];
    assign q1  = out_d[1];
    assign rv0 = rd_vld_q[0];
    assign rv1 = rd_vld_q[1];
  end
endmodule

// File: tb/tb_gsram_dp_init.sv
// Directed bench: registered-output and unregistered-output instances share stimulus.

module tb_gsram_dp_init;
  localparam int ID = 0, RD = 1, WR = 2;

  logic        clk = 1'b0, rstn = 1'b1, init_start = 1'b0;
  logic        ce0 = 0, we0 = 0, ce1 = 0, we1 = 0;
  logic [3:0]  a0 = '0, a1 = '0;
  logic [15:0] d0 = '0, d1 = '0;
  logic [1:0]  be0 = '0, be1 = '0;

  logic        r_busy, r_done, r_rv0, r_rv1, c_busy, c_done, c_rv0, c_rv1;
  logic [15:0] r_q0, r_q1, c_q0, c_q1;

  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  gsram_dp_init #(.ABITS(4), .DBITS(16), .OUT_REG(1'b1), .INIT_VAL(8'h00)) dut_r (
    .clk(clk), .rstn(rstn), .init_start(init_start), .init_busy(r_busy), .init_done(r_done),
    .a0(a0), .d0(d0), .be0(be0), .ce0(ce0), .we0(we0), .q0(r_q0), .rv0(r_rv0),
    .a1(a1), .d1(d1), .be1(be1), .ce1(ce1), .we1(we1), .q1(r_q1), .rv1(r_rv1));

  gsram_dp_init #(.ABITS(4), .DBITS(16), .OUT_REG(1'b0), .INIT_VAL(8'h00)) dut_c (
    .clk(clk), .rstn(rstn), .init_start(init_start), .init_busy(c_busy), .init_done(c_done),
    .a0(a0), .d0(d0), .be0(be0), .ce0(ce0), .we0(we0), .q0(c_q0), .rv0(c_rv0),
    .a1(a1), .d1(d1), .be1(be1), .ce1(ce1), .we1(we1), .q1(c_q1), .rv1(c_rv1));

  typedef struct {
    logic ce0, we0; logic [3:0] a0; logic [15:0] d0; logic [1:0] be0;
    logic ce1, we1; logic [3:0] a1; logic [15:0] d1; logic [1:0] be1;
    logic erv0; logic [15:0] eq0; logic erv1; logic [15:0] eq1;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(int o0, int x0, int y0, int b0, int o1, int x1, int y1, int b1,
                              int r0, int e0, int r1, int e1);
    vec_t v;
    v.ce0 = (o0 != ID); v.we0 = (o0 == WR); v.a0 = 4'(x0); v.d0 = 16'(y0); v.be0 = 2'(b0);
    v.ce1 = (o1 != ID); v.we1 = (o1 == WR); v.a1 = 4'(x1); v.d1 = 16'(y1); v.be1 = 2'(b1);
    v.erv0 = 1'(r0); v.eq0 = 16'(e0); v.erv1 = 1'(r1); v.eq1 = 16'(e1);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic port(input int p, input int op, input int a, input int d, input int be);
    if (p == 0) begin
      ce0 = (op != ID); we0 = (op == WR); a0 = 4'(a); d0 = 16'(d); be0 = 2'(be);
    end else begin
      ce1 = (op != ID); we1 = (op == WR); a1 = 4'(a); d1 = 16'(d); be1 = 2'(be);
    end
  endtask

  task automatic idle;
    port(0, ID, 0, 0, 0);
    port(1, ID, 0, 0, 0);
  endtask

  task automatic drive(input vec_t v);
    ce0 = v.ce0; we0 = v.we0; a0 = v.a0; d0 = v.d0; be0 = v.be0;
    ce1 = v.ce1; we1 = v.we1; a1 = v.a1; d1 = v.d1; be1 = v.be1;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_r_q0"}, r_q0, 0);   chk({nm, "_r_q1"}, r_q1, 0);
    chk({nm, "_c_q0"}, c_q0, 0);   chk({nm, "_c_q1"}, c_q1, 0);
    chk({nm, "_r_rv"}, {r_rv0, r_rv1, c_rv0, c_rv1}, 0);
    chk({nm, "_busy"}, {r_busy, c_busy}, 0);
    chk({nm, "_done"}, {r_done, c_done}, 0);
  endtask

  // Called right after reset release, at a falling edge.
  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      step;
      if (r_done) break;
      if (r_busy) n++;
    end
    chk({nm, "_busy_cycles"}, n, 8);
    chk({nm, "_done"}, {r_done, c_done}, 2'b11);
    chk({nm, "_busy_end"}, {r_busy, c_busy}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic done_seen;

    // Clear check: every address on both ports, pipelined
    for (int i = 0; i < 16; i++)
      vec.push_back(mk(RD, i, 0, 0, RD, 15 - i, 0, 0, i > 0, 0, i > 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 1, 0, 1, 0));
    // Byte-enable partial overwrite
    vec.push_back(mk(WR, 3, 'hABCD, 3, ID, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(WR, 3, 'h1234, 1, ID, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, RD, 3, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 0, 0, 1, 'hAB34));
    // Write/write collision, mixed enables
    vec.push_back(mk(WR, 5, 'h1111, 1, WR, 5, 'h2222, 3, 0, 0, 0, 0));
    vec.push_back(mk(RD, 5, 0, 0, ID, 0, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 1, 'h2211, 0, 0));
    // Write/write collision, port 0 full word
    vec.push_back(mk(WR, 6, 'hAAAA, 3, WR, 6, 'h5555, 3, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, RD, 6, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 0, 0, 1, 'hAAAA));
    // Cross-port read during write, both directions
    vec.push_back(mk(WR, 7, 'hBEEF, 2, RD, 7, 0, 0, 0, 0, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, RD, 7, 0, 0, 0, 0, 1, 'hBE00));
    vec.push_back(mk(RD, 9, 0, 0, WR, 9, 'h5678, 1, 0, 0, 1, 'hBE00));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 1, 'h0078, 0, 0));
    vec.push_back(mk(ID, 0, 0, 0, ID, 0, 0, 0, 0, 0, 0, 0));

    #2 rstn = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    step;
    chk_zero("reset_hold");
    rstn = 1'b1;
    wait_clear("clear");

    for (int r = 0; r < vec.size(); r++) begin
      drive(vec[r]);
      step;
      chk($sformatf("row%0d_r_rv0", r), r_rv0, vec[r].erv0);
      chk($sformatf("row%0d_r_rv1", r), r_rv1, vec[r].erv1);
      if (vec[r].erv0) chk($sformatf("row%0d_r_q0", r), r_q0, vec[r].eq0);
      if (vec[r].erv1) chk($sformatf("row%0d_r_q1", r), r_q1, vec[r].eq1);
      if (r + 1 < vec.size()) begin
        chk($sformatf("row%0d_c_rv0", r), c_rv0, vec[r+1].erv0);
        chk($sformatf("row%0d_c_rv1", r), c_rv1, vec[r+1].erv1);
        if (vec[r+1].erv0) chk($sformatf("row%0d_c_q0", r), c_q0, vec[r+1].eq0);
        if (vec[r+1].erv1) chk($sformatf("row%0d_c_q1", r), c_q1, vec[r+1].eq1);
      end
    end
    chk("hold_r_q0", r_q0, 'h0078);
    chk("hold_c_q0", c_q0, 'h0078);

    // Fill, then re-clear with a read in flight and user traffic during busy
    for (int k = 0; k < 8; k++) begin
      port(0, WR, 2*k, 'hA500 | (2*k), 3);
      port(1, WR, 2*k + 1, 'hA500 | (2*k + 1), 3);
      step;
    end
    port(0, RD, 4, 0, 0);
    port(1, ID, 0, 0, 0);
    init_start = 1'b1;
    step;
    init_start = 1'b0;
    chk("inflight_c_rv0", c_rv0, 1);
    chk("inflight_c_q0", c_q0, 'hA504);
    chk("inflight_r_rv0", r_rv0, 0);
    chk("reinit_busy", {r_busy, r_done}, 2'b10);
    n = 1;
    done_seen = 1'b0;
    port(0, WR, 0, 'hFFFF, 3);
    port(1, RD, 1, 0, 0);
    for (int k = 0; k < 30; k++) begin
      step;
      if (k == 0) begin
        chk("inflight_r_rv0_late", r_rv0, 1);
        chk("inflight_r_q0", r_q0, 'hA504);
      end else begin
        chk($sformatf("busy%0d_r_rv0", k), r_rv0, 0);
      end
      chk($sformatf("busy%0d_c_rv0", k), c_rv0, 0);
      chk($sformatf("busy%0d_rv1", k), {r_rv1, c_rv1}, 0);
      if (r_done) begin
        done_seen = 1'b1;
        break;
      end
      if (r_busy) n++;
      init_start = (k == 2);
    end
    init_start = 1'b0;
    idle;
    chk("reinit_busy_cycles", n, 8);
    chk("reinit_done", done_seen, 1);
    for (int a = 0; a < 16; a++) begin
      port(0, RD, a, 0, 0);
      port(1, RD, 15 - a, 0, 0);
      step;
      chk($sformatf("rd%0d_c_rv", a), {c_rv0, c_rv1}, 2'b11);
      chk($sformatf("rd%0d_c_q", a), {c_q0, c_q1}, 0);
      idle;
      step;
      chk($sformatf("rd%0d_r_rv", a), {r_rv0, r_rv1}, 2'b11);
      chk($sformatf("rd%0d_r_q", a), {r_q0, r_q1}, 0);
    end

    // Reset abort in the middle of a clear
    port(0, WR, 2, 'h5A5A, 3);
    step;
    port(0, RD, 2, 0, 0);
    step;
    idle;
    step;
    chk("pre_abort_r_q0", r_q0, 'h5A5A);
    chk("pre_abort_c_q0", c_q0, 'h5A5A);
    init_start = 1'b1;
    step;
    init_start = 1'b0;
    step;
    step;
    chk("abort_at_busy3", r_busy, 1);
    rstn = 1'b0;
    #1;
    chk_zero("abort");
    @(negedge clk);
    rstn = 1'b1;
    wait_clear("reclear");
    port(0, WR, 3, 'h0F0F, 3);
    step;
    port(0, RD, 3, 0, 0);
    port(1, RD, 2, 0, 0);
    step;
    idle;
    chk("lat1_c_rv", {c_rv0, c_rv1}, 2'b11);
    chk("lat1_c_q0", c_q0, 'h0F0F);
    chk("lat1_c_q1", c_q1, 0);
    chk("lat1_r_rv", {r_rv0, r_rv1}, 0);
    step;
    chk("lat2_r_rv", {r_rv0, r_rv1}, 2'b11);
    chk("lat2_r_q0", r_q0, 'h0F0F);
    chk("lat2_r_q1", r_q1, 0);
    chk("lat2_c_rv", {c_rv0, c_rv1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
